matmul_stream_ctrl: RTL and testbench
=====================================

Name: matmul_stream_ctrl

Overview:
- Streaming front-end for the parallel matrix multiplier.
- Accepts matrix elements over a valid/ready input stream and assembles A (MxN) and B (NxP) into flat register buses.
- Issues a one-cycle start to the multiplier and waits for its done.
- Drains result C (MxP) row-major over a valid/ready output stream; it is the initiator/consumer at the multiplier's start/done interface.

Parameters:
- M, 2, rows of A and C
- N, 2, columns of A and rows of B
- P, 2, columns of B and C
- W, 32, element width in bits; fixed to 32 for the current multiplier

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- s_valid  in  1  input element valid
- s_ready  out  1  input element accepted when s_valid && s_ready
- s_data  in  W  input element; A row-major, then B row-major
- m_valid  out  1  result element valid
- m_ready  in  1  downstream accepts when m_valid && m_ready
- m_data  out  W  result element C[i][j], row-major
- m_last  out  1  high with the final element C[M-1][P-1]
- busy  out  1  high in every state except LOAD_A with zero elements received
- mm_start  out  1  one-cycle start pulse to the multiplier
- mm_done  in  1  multiplier done; sticky high after first completion
- mm_a  out  M*N*W  flat A; element (i,k) at bits [(i*N+k)*W +: W]
- mm_b  out  N*P*W  flat B; element (k,j) at bits [(k*P+j)*W +: W]
- mm_c  in  M*P*W  flat C; element (i,j) at bits [(i*P+j)*W +: W]

Behaviour:
- Reset (async, active-high) values:
  - state = LOAD_A, element counter = 0
  - s_ready = 0, m_valid = 0, m_last = 0, m_data = 0, mm_start = 0, busy = 0
  - mm_a = 0, mm_b = 0
- States: LOAD_A -> LOAD_B -> START -> WAIT -> DRAIN -> LOAD_A.
- LOAD_A:
  - s_ready = 1.
  - Each handshake writes s_data to A element at index cnt; cnt increments.
  - On the handshake with cnt == M*N-1: cnt -> 0, go to LOAD_B.
- LOAD_B:
  - Same as LOAD_A, writing B.
  - After N*P handshakes go to START.
  - s_ready drops in the cycle after the final accept.
- START:
  - mm_start = 1 for exactly one cycle.
  - A and B are stable from this cycle until the next LOAD_A handshake.
  - Next state WAIT.
- WAIT:
  - mm_done is sampled from the first cycle after the start pulse.
  - mm_done high -> DRAIN, cnt = 0.
  - With the current multiplier, WAIT lasts 1 cycle. A stale done is impossible because C and done update on the same edge as the start sample.
- DRAIN:
  - m_valid = 1; m_data = C element cnt, registered.
  - m_last = (cnt == M*P-1).
  - m_data and m_last are held stable while m_valid && !m_ready.
  - On handshake cnt increments. On the handshake with m_last high: m_valid -> 0, cnt -> 0, go to LOAD_A.
- Counter width is $clog2(max(M*N, N*P, M*P)+1); there is no wrap beyond the terminal index.
- s_ready = 0 in START, WAIT and DRAIN. Input is back-pressured, never dropped.
- s_valid and m_ready may toggle arbitrarily; there is no combinational path from s_valid to s_ready or from m_ready to m_valid.
- Reset mid-operation: immediate return to reset values. Partial matrices are discarded and any pending drain is abandoned.
- Back-to-back jobs: the first A element of the next job may be accepted in the cycle after the m_last handshake.

Decomposition:
- Package matmul_pkg holds:
  - WORD_W = 32
  - state enum: LOAD_A, LOAD_B, START, WAIT, DRAIN
  - shared flat-index helper functions, reused by the multiplier wrapper
- No sub-module. Single FSM plus counter; the C read mux is inline.

Test Plan:
1. Basic job, M=N=P=2: stream 1,2,3,4,5,6,7,8 with s_valid held high, m_ready=1 -> exactly one mm_start pulse; m_data 19,22,43,50; m_last only with 50; busy low afterwards.
2. Input bubbles: same data with s_valid low on alternate cycles -> identical output. mm_start asserts only after the 8th accept; s_ready=0 from START through DRAIN.
3. Output back-pressure: m_ready low for 3 cycles on each element -> m_data/m_last held stable while stalled; 4 handshakes total; no element repeated or skipped.
4. Back-to-back jobs: second job A=I, B=[[9,8],[7,6]] presented immediately after the first m_last -> outputs 9,8,7,6; exactly one start pulse per job.
5. Reset mid-load and mid-drain: assert reset after 5 inputs, then after 2 outputs -> all outputs at reset values within the same cycle. A subsequent full job produces correct results.
6. Non-square, M=3 N=2 P=1: A=1..6, B=[2,3] -> C = 8,18,28; m_last on 28; 8 input handshakes.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared definitions for the matrix-multiplier streaming front-end and the multiplier wrapper.
// Holds the element width, the controller state encoding and the flat-bus index helpers.
package matmul_pkg;

   localparam int WORD_W = 32;

   typedef enum logic [2:0] {
      LOAD_A = 3'd0,
      LOAD_B = 3'd1,
      START  = 3'd2,
      WAIT   = 3'd3,
      DRAIN  = 3'd4
   } state_e;

   // Row-major linear index of element (row, col) in a matrix with ncols columns.
   function automatic int flat_idx(input int row, input int col, input int ncols);
      return row * ncols + col;
   endfunction

   // LSB position of linear element idx inside a flat bus of WORD_W-bit words.
   function automatic int elem_lsb(input int idx);
      return idx * WORD_W;
   endfunction

endpackage

// File: rtl/matmul_stream_ctrl_if.sv
// Element stream bundle: input stream (A then B) and output stream (C, row-major).
interface matmul_stream_ctrl_if import matmul_pkg::*; #(parameter int W = WORD_W) ();
   logic         s_valid;
   logic         s_ready;
   logic [W-1:0] s_data;
   logic         m_valid;
   logic         m_ready;
   logic [W-1:0] m_data;
   logic         m_last;

   modport master (output s_valid, s_data, m_ready,
                   input  s_ready, m_valid, m_data, m_last);
   modport slave  (input  s_valid, s_data, m_ready,
                   output s_ready, m_valid, m_data, m_last);
endinterface

// File: rtl/matmul_stream_ctrl.sv
// Streaming front-end: loads A and B from an element stream, kicks the multiplier,
// then drains C row-major over a registered valid/ready output.
module matmul_stream_ctrl import matmul_pkg::*; #(
   parameter int M = 2,
   parameter int N = 2,
   parameter int P = 2,
   parameter int W = WORD_W
) (
   input  logic               clk,
   input  logic               reset,
   matmul_stream_ctrl_if.slave st,
   output logic               busy,
   output logic               mm_start,
   input  logic               mm_done,
   output logic [M*N*W-1:0]   mm_a,
   output logic [N*P*W-1:0]   mm_b,
   input  logic [M*P*W-1:0]   mm_c
);

   localparam int NA   = M * N;
   localparam int NB   = N * P;
   localparam int NC   = M * P;
   localparam int NMAX = (NA > NB) ? ((NA > NC) ? NA : NC) : ((NB > NC) ? NB : NC);
   localparam int CW   = $clog2(NMAX + 1);

   localparam logic [CW-1:0] A_LAST = CW'(NA - 1);
   localparam logic [CW-1:0] B_LAST = CW'(NB - 1);
   localparam logic [CW-1:0] C_LAST = CW'(NC - 1);

   state_e        state;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nx;
   logic          s_hs;
   logic          m_hs;

   assign cnt_nx   = cnt + 1'b1;
   assign s_hs     = st.s_valid && st.s_ready;
   assign m_hs     = st.m_valid && st.m_ready;
   assign mm_start = (state == START);
   assign busy     = !((state == LOAD_A) && (cnt == '0));

   // s_ready/m_valid are registered so neither depends combinationally on the peer.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= LOAD_A;
         cnt        <= '0;
         st.s_ready <= 1'b0;
         st.m_valid <= 1'b0;
         st.m_last  <= 1'b0;
         st.m_data  <= '0;
         mm_a       <= '0;
         mm_b       <= '0;
      end else begin
         case (state)
            LOAD_A: begin
               st.s_ready <= 1'b1;
               if (s_hs) begin
                  mm_a[elem_lsb(int'(cnt)) +: W] <= st.s_data;
                  if (cnt == A_LAST) begin
                     cnt   <= '0;
                     state <= LOAD_B;
                  end else begin
                     cnt <= cnt_nx;
                  end
               end
            end
            LOAD_B: begin
               if (s_hs) begin
                  mm_b[elem_lsb(int'(cnt)) +: W] <= st.s_data;
                  if (cnt == B_LAST) begin
                     cnt        <= '0;
                     st.s_ready <= 1'b0;
                     state      <= START;
                  end else begin
                     cnt <= cnt_nx;
                  end
               end
            end
            START: state <= WAIT;
            WAIT: begin
               // C and done land on the start edge, so done here is always fresh.
               if (mm_done) begin
                  state      <= DRAIN;
                  cnt        <= '0;
                  st.m_valid <= 1'b1;
                  st.m_data  <= mm_c[0 +: W];
                  st.m_last  <= (C_LAST == '0);
               end
            end
            DRAIN: begin
               if (m_hs) begin
                  if (st.m_last) begin
                     st.m_valid <= 1'b0;
                     st.m_last  <= 1'b0;
                     st.s_ready <= 1'b1;
                     cnt        <= '0;
                     state      <= LOAD_A;
                  end else begin
                     cnt       <= cnt_nx;
                     st.m_data <= mm_c[elem_lsb(int'(cnt_nx)) +: W];
                     st.m_last <= (cnt_nx == C_LAST);
                  end
               end
            end
            default: state <= LOAD_A;
         endcase
      end
   end

endmodule

// File: tb/tb_matmul_stream_ctrl.sv
// Directed bench for matmul_stream_ctrl: a 2x2x2 instance and a 3x2x1 instance,
// each paired with a behavioural multiplier that registers C and a sticky done on start.
module tb_matmul_stream_ctrl;
   import matmul_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic reset;

   matmul_stream_ctrl_if #(.W(32)) if0 ();
   matmul_stream_ctrl_if #(.W(32)) if1 ();

   logic         busy0, start0, done0;
   logic [127:0] a0, b0, c0;
   logic [191:0] p0;
   logic         busy1, start1, done1;
   logic [191:0] a1;
   logic [63:0]  b1;
   logic [95:0]  c1;
   logic [191:0] p1;

   matmul_stream_ctrl #(.M(2), .N(2), .P(2), .W(32)) u0 (
      .clk(clk), .reset(reset), .st(if0.slave), .busy(busy0), .mm_start(start0),
      .mm_done(done0), .mm_a(a0), .mm_b(b0), .mm_c(c0));

   matmul_stream_ctrl #(.M(3), .N(2), .P(1), .W(32)) u1 (
      .clk(clk), .reset(reset), .st(if1.slave), .busy(busy1), .mm_start(start1),
      .mm_done(done1), .mm_a(a1), .mm_b(b1), .mm_c(c1));

   function automatic logic [191:0] mmul(input logic [191:0] a, input logic [191:0] b,
                                         input int m, input int n, input int p);
      logic [191:0] r;
      logic [31:0]  s;
      r = '0;
      for (int i = 0; i < m; i++)
         for (int j = 0; j < p; j++) begin
            s = '0;
            for (int k = 0; k < n; k++)
               s = s + a[(i*n+k)*32 +: 32] * b[(k*p+j)*32 +: 32];
            r[(i*p+j)*32 +: 32] = s;
         end
      return r;
   endfunction

   assign p0 = mmul({64'd0, a0}, {64'd0, b0}, 2, 2, 2);
   assign p1 = mmul(a1, {128'd0, b1}, 3, 2, 1);

   always @(posedge clk or posedge reset)
      if (reset) begin done0 <= 1'b0; c0 <= '0; end
      else if (start0) begin done0 <= 1'b1; c0 <= p0[127:0]; end

   always @(posedge clk or posedge reset)
      if (reset) begin done1 <= 1'b0; c1 <= '0; end
      else if (start1) begin done1 <= 1'b1; c1 <= p1[95:0]; end

   int starts0 = 0, starts1 = 0;
   always @(posedge clk) begin
      if (start0) starts0 <= starts0 + 1;
      if (start1) starts1 <= starts1 + 1;
   end

   int errors = 0, checks = 0;
   logic [31:0] din [12];
   logic [31:0] dexp [4];

   task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic rst_checks();
      chk("rst_s_ready", if0.s_ready, 0);
      chk("rst_m_valid", if0.m_valid, 0);
      chk("rst_m_last", if0.m_last, 0);
      chk("rst_m_data", if0.m_data, 0);
      chk("rst_mm_start", start0, 0);
      chk("rst_busy", busy0, 0);
      chk("rst_mm_a", a0, 0);
      chk("rst_mm_b", b0, 0);
      chk("rst_u1_s_ready", if1.s_ready, 0);
   endtask

   // Runs a job on u0; stops early after in_stop accepts or out_stop result handshakes.
   task automatic job0(input int nin, input int nout, input int in_stop, input int out_stop,
                       input bit bubble, input bit stall);
      int i_in, i_out, cyc, stl, s0;
      i_in = 0; i_out = 0; cyc = 0; stl = 0; s0 = starts0;
      while (i_out < out_stop && i_in < in_stop && cyc < 300) begin
         if0.s_valid = (i_in < nin) && !(bubble && (cyc % 2 == 1));
         if0.s_data  = din[i_in];
         if0.m_ready = !stall;
         if (if0.m_valid) begin
            chk("s_ready_low_drain", if0.s_ready, 0);
            chk("m_data", if0.m_data, dexp[i_out]);
            chk("m_last", if0.m_last, (i_out == nout - 1));
            if0.m_ready = !stall || (stl == 3);
            stl = if0.m_ready ? 0 : stl + 1;
            if (if0.m_ready) i_out++;
         end
         if (start0) begin
            chk("start_after_last_accept", i_in, nin);
            chk("s_ready_low_start", if0.s_ready, 0);
         end
         if (if0.s_valid && if0.s_ready) i_in++;
         step();
         cyc++;
      end
      if0.s_valid = 1'b0;
      chk("job0_timeout", (cyc < 300), 1);
      if (out_stop == nout && in_stop >= nin) begin
         chk("inputs_accepted", i_in, nin);
         chk("one_start_per_job", starts0 - s0, 1);
         chk("m_valid_after_last", if0.m_valid, 0);
      end
   endtask

   initial begin
      reset = 1'b1;
      if0.s_valid = 1'b0; if0.s_data = '0; if0.m_ready = 1'b0;
      if1.s_valid = 1'b0; if1.s_data = '0; if1.m_ready = 1'b0;
      step(); step();
      rst_checks();
      reset = 1'b0;
      step();
      chk("idle_busy", busy0, 0);
      chk("ready_after_reset", if0.s_ready, 1);

      // Basic job: A=[[1,2],[3,4]], B=[[5,6],[7,8]]
      for (int i = 0; i < 8; i++) din[i] = 32'(i + 1);
      dexp[0] = 32'd19; dexp[1] = 32'd22; dexp[2] = 32'd43; dexp[3] = 32'd50;
      job0(8, 4, 99, 4, 1'b0, 1'b0);
      chk("busy_after_job", busy0, 0);

      // Input bubbles, then output back-pressure
      job0(8, 4, 99, 4, 1'b1, 1'b0);
      job0(8, 4, 99, 4, 1'b0, 1'b1);

      // Back-to-back: A=I, B=[[9,8],[7,6]] presented right after previous m_last
      chk("b2b_ready", if0.s_ready, 1);
      din[0] = 32'd1; din[1] = 32'd0; din[2] = 32'd0; din[3] = 32'd1;
      din[4] = 32'd9; din[5] = 32'd8; din[6] = 32'd7; din[7] = 32'd6;
      dexp[0] = 32'd9; dexp[1] = 32'd8; dexp[2] = 32'd7; dexp[3] = 32'd6;
      job0(8, 4, 99, 4, 1'b0, 1'b0);

      // Reset after 5 inputs
      for (int i = 0; i < 8; i++) din[i] = 32'(i + 1);
      dexp[0] = 32'd19; dexp[1] = 32'd22; dexp[2] = 32'd43; dexp[3] = 32'd50;
      job0(8, 4, 5, 4, 1'b0, 1'b0);
      chk("mid_load_busy", busy0, 1);
      reset = 1'b1; #1;
      rst_checks();
      step(); reset = 1'b0; step();

      // Reset after 2 outputs
      job0(8, 4, 99, 2, 1'b0, 1'b0);
      chk("mid_drain_valid", if0.m_valid, 1);
      reset = 1'b1; #1;
      rst_checks();
      step(); reset = 1'b0; step();
      job0(8, 4, 99, 4, 1'b0, 1'b0);

      // Non-square 3x2x1: A=1..6, B=[2,3] -> C=8,18,28
      begin
         logic [31:0] din1 [12];
         logic [31:0] exp1 [3];
         int i_in, i_out, cyc, s1;
         for (int i = 0; i < 12; i++) din1[i] = (i < 6) ? 32'(i + 1) : 32'd0;
         din1[6] = 32'd2; din1[7] = 32'd3;
         exp1[0] = 32'd8; exp1[1] = 32'd18; exp1[2] = 32'd28;
         i_in = 0; i_out = 0; cyc = 0; s1 = starts1;
         while (i_out < 3 && cyc < 300) begin
            if1.s_valid = (i_in < 8);
            if1.s_data  = din1[i_in];
            if1.m_ready = 1'b1;
            if (if1.m_valid) begin
               chk("u1_m_data", if1.m_data, exp1[i_out]);
               chk("u1_m_last", if1.m_last, (i_out == 2));
               i_out++;
            end
            if (if1.s_valid && if1.s_ready) i_in++;
            step();
            cyc++;
         end
         if1.s_valid = 1'b0;
         chk("u1_timeout", (cyc < 300), 1);
         chk("u1_inputs_accepted", i_in, 8);
         chk("u1_one_start", starts1 - s1, 1);
         chk("u1_busy_after", busy1, 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
